mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : Multi-cycle multiply/divide sequencer owning the HI/LO registers.
//            MULT/MULTU stay busy for 5 cycles and DIV/DIVU for 10. The
//            result is committed to HI/LO on the last busy edge, and done
//            pulses on the cycle after that. MTHI/MTLO write HI/LO in a
//            single cycle. Issue stalls the front of the pipeline while
//            useMd is set.
// Options  : MDU_DIV0_SKIP_EN - when defined, a divide by zero is dropped at
//            issue. HI/LO are left unchanged, the unit never goes busy and no
//            stall is raised.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        useMd,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MTHI  = 3'd4;
  localparam logic [2:0] c_OP_MTLO  = 3'd5;
  localparam logic [3:0] c_CNT_MUL  = 4'd4;
  localparam logic [3:0] c_CNT_DIV  = 4'd9;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state, w_next_state;
  logic [3:0]  r_cnt, w_next_cnt;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [2:0]  r_op;
  logic        r_done;
  logic        w_accept, w_commit;
  logic        w_is_mul, w_is_div, w_div_go;
  logic [63:0] w_prod_s, w_prod_u;
  logic        w_signed, w_neg_q, w_neg_r;
  logic [31:0] w_na, w_nb, w_quo_u, w_rem_u;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_is_mul = (op == c_OP_MULT) || (op == c_OP_MULTU);
  assign w_is_div = (op == c_OP_DIV)  || (op == c_OP_DIVU);

`ifdef MDU_DIV0_SKIP_EN
  // A zero divisor is dropped at issue, so it neither runs nor stalls.
  assign w_div_go = w_is_div && (srcB != 32'd0);
`else
  assign w_div_go = w_is_div;
`endif

  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign stall = useMd & (busy | (start & (w_is_mul | w_div_go)));

  // State register and down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state logic: accept new work only in IDLE, commit when cnt hits zero.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_is_mul) begin
          w_next_state = S_RUN;
          w_next_cnt   = c_CNT_MUL;
          w_accept     = 1'b1;
        end else if (start && w_div_go) begin
          w_next_state = S_RUN;
          w_next_cnt   = c_CNT_DIV;
          w_accept     = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_IDLE;
          w_commit     = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The products are sized to 64 bits. The signed form sign-extends both
  // operands, so the low 64 bits of the product come out in two's complement.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed division is done on magnitudes. Taking the magnitude of 0x80000000
  // works unchanged in 32 unsigned bits, so the overflow case needs no
  // special handling.
  assign w_signed = (r_op == c_OP_DIV);
  assign w_na     = (w_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
  assign w_nb     = (w_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
  assign w_quo_u  = w_na / w_nb;
  assign w_rem_u  = w_na % w_nb;
  assign w_neg_q  = w_signed && (r_a[31] ^ r_b[31]);
  assign w_neg_r  = w_signed && r_a[31];

  // Result selection from the latched operands.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      c_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      c_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      c_OP_DIV, c_OP_DIVU: begin
        if (r_b == 32'd0) begin
          w_res_hi = r_a;
          w_res_lo = 32'hFFFF_FFFF;
        end else begin
          w_res_hi = w_neg_r ? (32'd0 - w_rem_u) : w_rem_u;
          w_res_lo = w_neg_q ? (32'd0 - w_quo_u) : w_quo_u;
        end
      end
      default: ;
    endcase
  end

  // Operand latch, HI/LO update and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_op   <= 3'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_a  <= srcA;
        r_b  <= srcB;
        r_op <= op;
      end
      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (r_state == S_IDLE && start && op == c_OP_MTHI) begin
        r_hi <= srcA;
      end else if (r_state == S_IDLE && start && op == c_OP_MTLO) begin
        r_lo <= srcA;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sequencer
// Purpose  : Directed self-checking bench for mdu_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;

  logic        clk, reset, start, useMd;
  logic [2:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  mdu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srcA  (srcA),
    .srcB  (srcB),
    .useMd (useMd),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div, check busy length, hold of HI/LO, ignored re-issue,
  // stall behaviour and the committed result with its single done pulse.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] eh, input logic [31:0] el,
                        input logic md, input string tag);
    start = 1'b1; op = o; srcA = a; srcB = b; useMd = md;
    #1;
    if (md) chk({tag, " stall@issue"}, {31'd0, stall}, 32'd1);
    step();
    // Scramble the operands and attempt an MTHI while busy.
    srcA = ~a; srcB = ~b; op = 3'd4; start = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) start = 1'b0;
      #1;
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " done-early"}, {31'd0, done}, 32'd0);
      chk({tag, " hi-hold"}, hi, m_hi);
      chk({tag, " lo-hold"}, lo, m_lo);
      if (md) chk({tag, " stall-busy"}, {31'd0, stall}, 32'd1);
      step();
    end
    chk({tag, " busy-end"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    if (md) chk({tag, " stall-after"}, {31'd0, stall}, 32'd0);
    m_hi = eh;
    m_lo = el;
    step();
    chk({tag, " done-1cyc"}, {31'd0, done}, 32'd0);
    useMd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; srcA = 32'd0; srcB = 32'd0; useMd = 1'b0;
    #12;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    reset = 1'b0;

    // First start after reset release is accepted on the very next edge.
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div");
    run_op(3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0, "divu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, "multu");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0, "div-ovf");
    run_op(3'd2, 32'd100, 32'hFFFF_FFF9, 10, 32'd2, 32'hFFFF_FFF2, 1'b0, "div-negb");

    // Abort a divide with an asynchronous reset in mid-cycle.
    start = 1'b1; op = 3'd2; srcA = 32'd100; srcB = 32'd7;
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post-abort done", {31'd0, done}, 32'd0);
      chk("post-abort busy", {31'd0, busy}, 32'd0);
      chk("post-abort lo", lo, 32'd0);
    end

    // MTHI / MTLO are single-cycle and never stall or go busy.
    start = 1'b1; op = 3'd4; srcA = 32'h1234_5678; useMd = 1'b1;
    #1;
    chk("mthi stall", {31'd0, stall}, 32'd0);
    step();
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi lo", lo, 32'd0);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    op = 3'd5; srcA = 32'd9;
    step();
    chk("mtlo lo", lo, 32'd9);
    chk("mtlo hi", hi, 32'h1234_5678);
    chk("mtlo busy", {31'd0, busy}, 32'd0);
    chk("mtlo done", {31'd0, done}, 32'd0);
    m_hi = 32'h1234_5678; m_lo = 32'd9;

    // Opcode 6 is a no-op.
    op = 3'd6; srcA = 32'hDEAD_BEEF;
    #1;
    chk("nop stall", {31'd0, stall}, 32'd0);
    step();
    chk("nop busy", {31'd0, busy}, 32'd0);
    chk("nop hi", hi, m_hi);
    chk("nop lo", lo, m_lo);
    start = 1'b0; useMd = 1'b0;
    step();

    // Divide by zero.
`ifdef MDU_DIV0_SKIP_EN
    start = 1'b1; op = 3'd2; srcA = 32'h55; srcB = 32'd0; useMd = 1'b1;
    #1;
    chk("div0 stall", {31'd0, stall}, 32'd0);
    step();
    start = 1'b0;
    chk("div0 busy", {31'd0, busy}, 32'd0);
    chk("div0 hi", hi, m_hi);
    chk("div0 lo", lo, m_lo);
    step();
    chk("div0 done", {31'd0, done}, 32'd0);
    useMd = 1'b0;
`else
    run_op(3'd2, 32'h55, 32'd0, 10, 32'h55, 32'hFFFF_FFFF, 1'b1, "div0");
    run_op(3'd3, 32'h8000_0001, 32'd0, 10, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0, "divu0");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
